// File: rtl/mult_cell_sequencer.sv
// mult_cell_sequencer
//   Two-requester round-robin sequencer for a shared 16x16 multiplier cell
//   that produces three partial products. It accepts one request at a time,
//   drives the cell operands and enable for CELL_LATENCY cycles, combines the
//   partial products into (src1*src2) mod 2^32 and returns the result on a
//   valid/ready response port.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   flush           synchronous abort of the in-flight op (no response)
//   req_valid[1:0]  request strobe per requester (bit i = requester i)
//   req_src1/2      {requester1 operand, requester0 operand}, 32b each
//   req_ready[1:0]  one-hot accept, IDLE only
//   resp_valid/id/result, resp_ready   response handshake
//   cell_src1/2, cell_en, cell_reset_n outputs to the multiplier cell
//   cell_p1/p2/p3   partial products from the cell
module mult_cell_sequencer #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic [1:0]  req_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  input  logic        resp_ready,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  output logic        cell_reset_n,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    COMBINE = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(CELL_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lat_cnt;
  logic       rr;        // requester favoured on a conflict
  logic       grant_id;
  logic       accept;
  logic       lat_done;

  assign cell_reset_n = ~reset;

  // Single requester wins outright; on a conflict the rr pointer decides.
  assign grant_id = (req_valid == 2'b11) ? rr : req_valid[1];
  assign accept   = |(req_valid & req_ready);
  assign lat_done = (lat_cnt == LAT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (accept) state_nxt = ISSUE;
      ISSUE, WAIT: begin
        if (flush)         state_nxt = IDLE;
        else if (lat_done) state_nxt = COMBINE;
        else               state_nxt = WAIT;
      end
      COMBINE:     state_nxt = flush ? IDLE : RESP;
      RESP:        if (flush || resp_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = '0;
    cell_en    = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE:        if (!flush && (|req_valid)) req_ready = grant_id ? 2'b10 : 2'b01;
      ISSUE, WAIT: cell_en = 1'b1;
      RESP:        resp_valid = 1'b1;
      default:     ;
    endcase
  end

  // Datapath: operand latch, latency counter, result combine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_src1   <= '0;
      cell_src2   <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      rr          <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      if (accept) begin
        cell_src1 <= grant_id ? req_src1[63:32] : req_src1[31:0];
        cell_src2 <= grant_id ? req_src2[63:32] : req_src2[31:0];
        resp_id   <= grant_id;
        rr        <= ~grant_id;
        lat_cnt   <= '0;
      end else if ((state == ISSUE || state == WAIT) && !lat_done) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      // p2 and p3 both carry weight 2^16; their sum wraps at 32 bits before
      // the shift, which only discards bits above 2^32 of the full product.
      if (state == COMBINE && !flush)
        resp_result <= cell_p1 + ((cell_p2 + cell_p3) << 16);
    end
  end

endmodule

// File: tb/tb_mult_cell_sequencer.sv
// Bench for mult_cell_sequencer: four instances with CELL_LATENCY 1..4, each
// attached to a pipelined partial-product cell model of matching depth.
module tb_mult_cell_sequencer;

  logic        clk;
  logic        reset;
  logic        flush       [4];
  logic [1:0]  req_valid   [4];
  logic [63:0] req_src1    [4];
  logic [63:0] req_src2    [4];
  logic        resp_ready  [4];
  logic [1:0]  req_ready   [4];
  logic        resp_valid  [4];
  logic        resp_id     [4];
  logic [31:0] resp_result [4];
  logic [31:0] cell_src1   [4];
  logic [31:0] cell_src2   [4];
  logic        cell_en     [4];
  logic        cell_reset_n[4];

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] pp(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_lat
    logic [95:0] pipe [0:g];

    mult_cell_sequencer #(.CELL_LATENCY(g + 1)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush[g]),
      .req_valid    (req_valid[g]),
      .req_src1     (req_src1[g]),
      .req_src2     (req_src2[g]),
      .req_ready    (req_ready[g]),
      .resp_valid   (resp_valid[g]),
      .resp_id      (resp_id[g]),
      .resp_result  (resp_result[g]),
      .resp_ready   (resp_ready[g]),
      .cell_src1    (cell_src1[g]),
      .cell_src2    (cell_src2[g]),
      .cell_en      (cell_en[g]),
      .cell_reset_n (cell_reset_n[g]),
      .cell_p1      (pipe[g][95:64]),
      .cell_p2      (pipe[g][63:32]),
      .cell_p3      (pipe[g][31:0])
    );

    always_ff @(posedge clk or negedge cell_reset_n[g]) begin
      if (!cell_reset_n[g]) begin
        for (int j = 0; j <= g; j++) pipe[j] <= '0;
      end else if (cell_en[g]) begin
        pipe[0] <= {pp(cell_src1[g][15:0],  cell_src2[g][15:0]),
                    pp(cell_src1[g][15:0],  cell_src2[g][31:16]),
                    pp(cell_src1[g][31:16], cell_src2[g][15:0])};
        for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Runs one operation on instance k with requests already driven and
  // resp_ready high; returns one cycle after the response handshake.
  task automatic op(input int k, input logic exp_id, input logic [31:0] exp_res);
    int n;
    int en_cnt;
    #1;
    n = 0;
    while (req_ready[k] == 2'b00 && n < 20) begin step(); n++; end
    chk("grant", req_ready[k], exp_id ? 2'b10 : 2'b01);
    step();
    n = 1;
    en_cnt = 0;
    while (!resp_valid[k] && n < 20) begin
      en_cnt += int'(cell_en[k]);
      step();
      n++;
    end
    chk("latency", n, k + 3);
    chk("en_cycles", en_cnt, k + 1);
    chk("resp_id", resp_id[k], exp_id);
    chk("resp_result", resp_result[k], exp_res);
    step();
    chk("resp_drop", resp_valid[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        id;

    for (int i = 0; i < 4; i++) begin
      flush[i] = 1'b0; req_valid[i] = '0; req_src1[i] = '0;
      req_src2[i] = '0; resp_ready[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",   req_ready[0],    2'b00);
    chk("rst_resp_valid",  resp_valid[0],   1'b0);
    chk("rst_resp_id",     resp_id[0],      1'b0);
    chk("rst_resp_result", resp_result[0],  32'h0);
    chk("rst_cell_src1",   cell_src1[0],    32'h0);
    chk("rst_cell_src2",   cell_src2[0],    32'h0);
    chk("rst_cell_en",     cell_en[0],      1'b0);
    chk("rst_cell_rst_n",  cell_reset_n[0], 1'b0);
    reset = 1'b0;
    #1;
    chk("cell_rst_n_rel",  cell_reset_n[0], 1'b1);
    step();

    // Requester 0, cycle-by-cycle on LAT=1
    req_src1[0] = {32'h0, 32'h00010002};
    req_src2[0] = {32'h0, 32'h00030004};
    req_valid[0] = 2'b01;
    resp_ready[0] = 1'b1;
    #1;
    chk("t1_ready", req_ready[0], 2'b01);
    step();
    req_valid[0] = 2'b00;
    #1;
    chk("t1_c1_en",    cell_en[0],   1'b1);
    chk("t1_c1_src1",  cell_src1[0], 32'h00010002);
    chk("t1_c1_src2",  cell_src2[0], 32'h00030004);
    chk("t1_c1_ready", req_ready[0], 2'b00);
    chk("t1_c1_valid", resp_valid[0], 1'b0);
    step();
    chk("t1_c2_en",    cell_en[0],    1'b0);
    chk("t1_c2_valid", resp_valid[0], 1'b0);
    step();
    chk("t1_c3_valid",  resp_valid[0],  1'b1);
    chk("t1_c3_id",     resp_id[0],     1'b0);
    chk("t1_c3_result", resp_result[0], 32'h000A0008);
    step();
    chk("t1_c4_valid",  resp_valid[0],  1'b0);

    // Requester 1, all-ones operands, response back-pressured
    req_src1[0] = {32'hFFFFFFFF, 32'h0};
    req_src2[0] = {32'hFFFFFFFF, 32'h0};
    req_valid[0] = 2'b10;
    resp_ready[0] = 1'b0;
    #1;
    chk("t2_ready", req_ready[0], 2'b10);
    step();
    req_valid[0] = 2'b11;
    step();
    step();
    chk("t2_valid",  resp_valid[0],  1'b1);
    chk("t2_id",     resp_id[0],     1'b1);
    chk("t2_result", resp_result[0], 32'h00000001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid",  resp_valid[0],  1'b1);
      chk("stall_id",     resp_id[0],     1'b1);
      chk("stall_result", resp_result[0], 32'h00000001);
      chk("stall_ready",  req_ready[0],   2'b00);
    end
    req_valid[0] = 2'b00;
    resp_ready[0] = 1'b1;
    step();
    chk("t2_release", resp_valid[0], 1'b0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    req_src1[0] = {32'h0000FFFF, 32'h00001234};
    req_src2[0] = {32'h00010001, 32'h00000100};
    req_valid[0] = 2'b11;
    op(0, 1'b0, 32'h00123400);
    op(0, 1'b1, 32'hFFFFFFFF);
    op(0, 1'b0, 32'h00123400);
    op(0, 1'b1, 32'hFFFFFFFF);
    req_valid[0] = 2'b00;
    step();

    // Flush during WAIT on LAT=2
    req_src1[1] = {32'h0, 32'h00000100};
    req_src2[1] = {32'h0, 32'h00000003};
    req_valid[1] = 2'b01;
    resp_ready[1] = 1'b1;
    #1;
    chk("fl_ready", req_ready[1], 2'b01);
    step();
    req_valid[1] = 2'b00;
    step();
    chk("fl_wait_en", cell_en[1], 1'b1);
    flush[1] = 1'b1;
    step();
    flush[1] = 1'b0;
    #1;
    chk("fl_en_off", cell_en[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_no_resp", resp_valid[1], 1'b0);
    end
    // Flush in IDLE blocks the grant without starting an op
    req_src1[1] = {32'h0, 32'd7};
    req_src2[1] = {32'h0, 32'd6};
    req_valid[1] = 2'b01;
    flush[1] = 1'b1;
    #1;
    chk("fl_idle_block", req_ready[1], 2'b00);
    step();
    chk("fl_idle_block2", req_ready[1], 2'b00);
    flush[1] = 1'b0;
    #1;
    chk("fl_idle_grant", req_ready[1], 2'b01);
    op(1, 1'b0, 32'd42);
    req_valid[1] = 2'b00;

    // Asynchronous reset while in COMBINE
    req_src1[0] = {32'h0, 32'd5};
    req_src2[0] = {32'h0, 32'd9};
    req_valid[0] = 2'b01;
    resp_ready[0] = 1'b1;
    step();
    req_valid[0] = 2'b00;
    step();
    chk("rc_pre_result", resp_result[0], 32'hFFFFFFFF);
    #2;
    reset = 1'b1;
    #1;
    chk("rc_result", resp_result[0],  32'h0);
    chk("rc_valid",  resp_valid[0],   1'b0);
    chk("rc_src1",   cell_src1[0],    32'h0);
    chk("rc_src2",   cell_src2[0],    32'h0);
    chk("rc_en",     cell_en[0],      1'b0);
    chk("rc_rst_n",  cell_reset_n[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rc_no_stale", resp_valid[0], 1'b0);
    end

    // Latency sweep with random operands
    for (int k = 0; k < 4; k++) begin
      resp_ready[k] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        a  = $urandom;
        b  = $urandom;
        id = 1'(i) ^ 1'(k);
        req_src1[k] = id ? {a, 32'($urandom)} : {32'($urandom), a};
        req_src2[k] = id ? {b, 32'($urandom)} : {32'($urandom), b};
        req_valid[k] = id ? 2'b10 : 2'b01;
        op(k, id, a * b);
        req_valid[k] = 2'b00;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
